// File: rtl/usb_tx_pkg.sv
// Shared encodings and constants for the full-speed USB low-level transmitter.
// Line states are packed as {dp, dn}.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP_SE0,
    EOP_J
  } state_t;

  typedef logic [1:0] line_t;

  localparam line_t LINE_J   = 2'b10;
  localparam line_t LINE_K   = 2'b01;
  localparam line_t LINE_SE0 = 2'b00;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam int         STUFF_LIMIT  = 6;
  localparam int         EOP_SE0_BITS = 2;

  function automatic line_t nrzi_toggle(input line_t level);
    return (level == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/usb_tx_nrzi_stuff.sv
// Bit stuffer and NRZI encoder: turns one bit per strobe into a J/K line state.
// line_next is the state the line takes at this strobe; stall marks a stuffed slot.
module usb_tx_nrzi_stuff
  import usb_tx_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  stb,
  input  logic  bit_in,
  input  logic  clear,
  output line_t line_next,
  output logic  stall
);

  line_t      level;
  logic [2:0] ones;
  logic       toggle;

  // Six ones in a row force a 0 into the next slot; the input bit waits.
  assign stall  = (ones == 3'(STUFF_LIMIT));
  assign toggle = stall || !bit_in;

  always_comb begin
    line_next = level;
    if (toggle) line_next = nrzi_toggle(level);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= LINE_J;
      ones  <= '0;
    end else if (clear) begin
      level <= LINE_J;
      ones  <= '0;
    end else if (stb) begin
      level <= line_next;
      if (toggle) ones <= '0;
      else        ones <= ones + 3'd1;
    end
  end

endmodule

// File: rtl/usb_tx_ll.sv
// Full-speed USB low-level transmitter: byte stream in, SYNC/data/stuffing/NRZI/EOP out.
// State names the next wire slot to be emitted at the coming bit strobe.
//
//   state   | meaning
//   IDLE    | line released (J, tx_en=0), waiting for in_valid
//   SYNC    | emitting the 8 SYNC bits
//   DATA    | emitting shift-register bits and stuff bits, reloading per byte
//   EOP_SE0 | pending stuff bit (normal end only), then SE0 slots
//   EOP_J   | J slot, then release the line on the following strobe
module usb_tx_ll
  import usb_tx_pkg::*;
#(
  parameter int BIT_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       tx_dp,
  output logic       tx_dn,
  output logic       tx_en,
  output logic       busy,
  output logic       underrun
);

  localparam int TW = $clog2(BIT_DIV);

  state_t         state;
  logic [TW-1:0]  timer;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           last;
  logic           abort;
  logic [1:0]     eop_cnt;

  logic  strobe;
  logic  nrzi_bit;
  logic  nrzi_stb;
  logic  nrzi_clear;
  logic  stall;
  line_t line_next;

  assign strobe   = (state != IDLE) && (timer == '0);
  assign nrzi_bit = (state == SYNC) ? SYNC_PATTERN[bit_cnt] : shreg[0];

  // An abandoned packet goes straight to SE0 even if a stuff bit was due.
  assign nrzi_stb = strobe && ((state == SYNC) || (state == DATA) ||
                               ((state == EOP_SE0) && stall && !abort));
  assign nrzi_clear = strobe && (state == EOP_J) && (eop_cnt != '0);

  usb_tx_nrzi_stuff u_nrzi_stuff (
    .clk       (clk),
    .rst       (rst),
    .stb       (nrzi_stb),
    .bit_in    (nrzi_bit),
    .clear     (nrzi_clear),
    .line_next (line_next),
    .stall     (stall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      last     <= 1'b0;
      abort    <= 1'b0;
      eop_cnt  <= '0;
      tx_dp    <= 1'b1;
      tx_dn    <= 1'b0;
      tx_en    <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b0;
      underrun <= 1'b0;
    end else begin
      in_ready <= 1'b0;
      underrun <= 1'b0;

      if (state == IDLE)                     timer <= '0;
      else if (timer == TW'(BIT_DIV - 1))    timer <= '0;
      else                                   timer <= timer + TW'(1);

      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b1;
            shreg    <= in_data;
            last     <= in_last;
            bit_cnt  <= '0;
            abort    <= 1'b0;
            eop_cnt  <= '0;
            state    <= SYNC;
          end
        end

        SYNC: begin
          if (strobe) begin
            {tx_dp, tx_dn} <= line_next;
            tx_en          <= 1'b1;
            busy           <= 1'b1;
            bit_cnt        <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= DATA;
          end
        end

        DATA: begin
          if (strobe) begin
            {tx_dp, tx_dn} <= line_next;
            if (!stall) begin
              shreg   <= {1'b0, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                // Reload decision is taken while bit 7 goes out, so bytes abut.
                if (last) begin
                  state <= EOP_SE0;
                end else if (in_valid) begin
                  in_ready <= 1'b1;
                  shreg    <= in_data;
                  last     <= in_last;
                end else begin
                  underrun <= 1'b1;
                  abort    <= 1'b1;
                  state    <= EOP_SE0;
                end
              end
            end
          end
        end

        EOP_SE0: begin
          if (strobe) begin
            if (stall && !abort) begin
              {tx_dp, tx_dn} <= line_next;
            end else begin
              {tx_dp, tx_dn} <= LINE_SE0;
              if (eop_cnt == 2'(EOP_SE0_BITS - 1)) begin
                eop_cnt <= '0;
                state   <= EOP_J;
              end else begin
                eop_cnt <= eop_cnt + 2'd1;
              end
            end
          end
        end

        EOP_J: begin
          if (strobe) begin
            if (eop_cnt == '0) begin
              {tx_dp, tx_dn} <= LINE_J;
              eop_cnt        <= 2'd1;
            end else begin
              tx_en   <= 1'b0;
              busy    <= 1'b0;
              eop_cnt <= '0;
              timer   <= '0;
              state   <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_ll.sv
// Self-checking bench for usb_tx_ll: a slot-level wire model built from the byte
// list is compared against the DUT outputs on every clock of every packet.
module tb_usb_tx_ll;

  localparam int BD = 4;
  localparam logic [1:0] J = 2'b10;
  localparam logic [1:0] K = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid, in_last;
  logic       in_ready, tx_dp, tx_dn, tx_en, busy, underrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  usb_tx_ll #(.BIT_DIV(BD)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .tx_dp    (tx_dp),
    .tx_dn    (tx_dn),
    .tx_en    (tx_en),
    .busy     (busy),
    .underrun (underrun)
  );

  // Reference model state
  logic [7:0] byte_q[$];
  logic [1:0] slots[$];
  int         rdy_at[$];
  int         und_at;
  logic [1:0] m_lvl;
  int         m_ones;
  int         last_en_clks;

  task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, c, got, exp);
    end
  endtask

  function automatic logic [1:0] tog(input logic [1:0] l);
    return (l == J) ? K : J;
  endfunction

  // Wire rule: a stuffed 0 precedes any bit that follows six consecutive ones.
  task automatic put_bit(input logic b);
    if (m_ones == 6) begin
      m_lvl = tog(m_lvl);
      slots.push_back(m_lvl);
      m_ones = 0;
    end
    if (b) m_ones++;
    else begin
      m_lvl  = tog(m_lvl);
      m_ones = 0;
    end
    slots.push_back(m_lvl);
  endtask

  task automatic build(input int n_acc);
    logic [7:0] sync_b;
    logic [7:0] b;
    int n;
    n = byte_q.size();
    sync_b = 8'h80;
    slots.delete();
    rdy_at.delete();
    und_at = -1;
    m_lvl  = J;
    m_ones = 0;
    for (int i = 0; i < 8; i++) put_bit(sync_b[i]);
    for (int k = 0; k < n_acc; k++) begin
      b = byte_q[k];
      for (int i = 0; i < 8; i++) put_bit(b[i]);
      if (k < n - 1) begin
        if (k + 1 < n_acc) rdy_at.push_back(slots.size() - 1);
        else               und_at = slots.size() - 1;
      end
    end
    if (und_at < 0 && m_ones == 6) begin
      m_lvl = tog(m_lvl);
      slots.push_back(m_lvl);
    end
    slots.push_back(SE0);
    slots.push_back(SE0);
    slots.push_back(J);
  endtask

  task automatic drive_next(input int idx, input int n_acc);
    if (idx < n_acc) begin
      in_valid = 1'b1;
      in_data  = byte_q[idx];
      in_last  = (idx == byte_q.size() - 1);
    end else begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_last  = 1'($urandom);
    end
  endtask

  // Runs one packet from IDLE to the cycle after tx_en falls, checking every clock.
  task automatic run_packet(input int n_acc, input int gap);
    int nslots, idx, en_clks;
    logic [1:0] exp_line;
    logic exp_en, exp_rdy, exp_und;
    build(n_acc);
    nslots = slots.size();
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      chk("idle_tx_en", -1, tx_en, 1'b0);
      chk("idle_line", -1, {tx_dp, tx_dn}, J);
    end
    drive_next(0, n_acc);
    @(negedge clk);
    chk("start_ready", 0, in_ready, 1'b1);
    chk("start_tx_en", 0, tx_en, 1'b0);
    idx = 1;
    drive_next(idx, n_acc);
    en_clks = 0;
    for (int c = 1; c <= nslots * BD + 1; c++) begin
      @(negedge clk);
      exp_en   = (c <= nslots * BD);
      exp_line = exp_en ? slots[(c - 1) / BD] : J;
      exp_rdy  = 1'b0;
      foreach (rdy_at[i]) if (1 + rdy_at[i] * BD == c) exp_rdy = 1'b1;
      exp_und  = (und_at >= 0) && (c == 1 + und_at * BD);
      chk("line", c, {tx_dp, tx_dn}, exp_line);
      chk("tx_en", c, tx_en, exp_en);
      chk("busy", c, busy, exp_en);
      chk("in_ready", c, in_ready, exp_rdy);
      chk("underrun", c, underrun, exp_und);
      if (tx_en) en_clks++;
      if (in_ready) begin
        idx++;
        drive_next(idx, n_acc);
      end
    end
    chk("en_clks", -1, en_clks, nslots * BD);
    last_en_clks = en_clks;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_dp"}, -1, tx_dp, 1'b1);
    chk({tag, "_tx_dn"}, -1, tx_dn, 1'b0);
    chk({tag, "_tx_en"}, -1, tx_en, 1'b0);
    chk({tag, "_busy"}, -1, busy, 1'b0);
    chk({tag, "_in_ready"}, -1, in_ready, 1'b0);
    chk({tag, "_underrun"}, -1, underrun, 1'b0);
  endtask

  initial begin
    logic [1:0] exp00[19];
    int n, n_acc;
    exp00 = '{K, J, K, J, K, J, K, K, J, K, J, K, J, K, J, K, SE0, SE0, J};

    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // Single 0x00: pin the model against the hand-derived wire, then run it.
    byte_q = '{8'h00};
    build(1);
    chk("model00_len", -1, slots.size(), 19);
    for (int i = 0; i < 19; i++) chk("model00_slot", i, slots[i], exp00[i]);
    run_packet(1, 1);
    chk("en_clks_00", -1, last_en_clks, 76);

    // Single 0xFF: one stuff bit after data bit 4.
    byte_q = '{8'hFF};
    build(1);
    chk("modelFF_len", -1, slots.size(), 20);
    chk("modelFF_stuff", 13, slots[13], J);
    run_packet(1, 2);

    // Two 0xFF bytes back to back.
    byte_q = '{8'hFF, 8'hFF};
    build(2);
    chk("modelFFFF_len", -1, slots.size(), 29);
    run_packet(2, 0);

    // Underrun after 0xC3, then a fresh packet.
    byte_q = '{8'hC3, 8'h55};
    build(1);
    chk("modelC3_und_slot", -1, und_at, 15);
    run_packet(1, 0);
    byte_q = '{8'h00};
    run_packet(1, 0);

    // Six trailing ones: stuff bit immediately before SE0.
    byte_q = '{8'hFC};
    build(1);
    chk("modelFC_stuff", 16, slots[16], J);
    chk("modelFC_se0", 17, slots[17], SE0);
    run_packet(1, 1);
    byte_q = '{8'hFE};
    run_packet(1, 1);

    // Asynchronous reset during DATA.
    byte_q = '{8'h00};
    in_valid = 1'b1;
    in_data  = 8'h00;
    in_last  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (45) @(negedge clk);
    chk("pre_rst_tx_en", -1, tx_en, 1'b1);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    run_packet(1, 1);
    chk("en_clks_after_rst", -1, last_en_clks, 76);

    // Randomized packets, with occasional underruns.
    for (int p = 0; p < 30; p++) begin
      n = $urandom_range(1, 4);
      byte_q.delete();
      for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
      n_acc = n;
      if (n > 1 && $urandom_range(0, 3) == 0) n_acc = $urandom_range(1, n - 1);
      run_packet(n_acc, $urandom_range(0, 5));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
